// File: rtl/branch_pkg.sv
// Shared branch constants: ALU compare opcodes (funct3) and the branch result encoding.
package branch_pkg;

  localparam logic [2:0] ALU_CMP_EQ  = 3'b000;
  localparam logic [2:0] ALU_CMP_NE  = 3'b001;
  localparam logic [2:0] ALU_CMP_LT  = 3'b100;
  localparam logic [2:0] ALU_CMP_GE  = 3'b101;
  localparam logic [2:0] ALU_CMP_LTU = 3'b110;
  localparam logic [2:0] ALU_CMP_GEU = 3'b111;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JUMP = 2'b10;

endpackage

// File: rtl/branch_cond_eval.sv
// Pure combinational branch condition evaluation from the ALU compare result.
module branch_cond_eval #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] alu_result,
  input  logic [2:0]      cmp_opcode,
  output logic            cond_taken
);
  import branch_pkg::*;

  // Decode funct3; reserved encodings 010/011 resolve not-taken.
  always_comb begin
    cond_taken = 1'b0;
    case (cmp_opcode)
      ALU_CMP_EQ:  cond_taken = (alu_result == {XLEN{1'b0}});
      ALU_CMP_NE:  cond_taken = (alu_result != {XLEN{1'b0}});
      ALU_CMP_LT:  cond_taken = alu_result[0];
      ALU_CMP_LTU: cond_taken = alu_result[0];
      ALU_CMP_GE:  cond_taken = ~alu_result[0];
      ALU_CMP_GEU: cond_taken = ~alu_result[0];
      default:     cond_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Direct-mapped BHT branch predictor with EX-stage resolution and registered redirect.
// Optional performance counters are built when BRANCH_PRED_PERF_EN is defined.
module branch_pred_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 2,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_jump,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [2:0]        ex_cmp_opcode,
  output logic [1:0]        branch,
  output logic              redirect,
  output logic              redirect_taken,
  output logic [PERF_W-1:0] perf_branch_cnt,
  output logic [PERF_W-1:0] perf_mispred_cnt
);
  import branch_pkg::*;

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};

  logic [IDX_W-1:0] fetch_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic             cond_taken_s;
  logic             res_s;
  logic             actual_s;
  logic             mispred_s;
  logic             bht_upd_s;
  logic [CNT_W-1:0] cnt_cur_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] bht_r [BHT_ENTRIES];
  logic             unused_s;

  assign fetch_idx_s = fetch_pc[IDX_W+1:2];
  assign ex_idx_s    = ex_pc[IDX_W+1:2];
  assign unused_s    = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                         ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // Read-before-write: a same-cycle update is seen only after the edge.
  assign pred_taken = bht_r[fetch_idx_s][CNT_W-1];

  branch_cond_eval #(.XLEN(XLEN)) u_cond_eval (
    .alu_result (ex_alu_result),
    .cmp_opcode (ex_cmp_opcode),
    .cond_taken (cond_taken_s)
  );

  // Resolution and saturating next-counter value.
  always_comb begin
    res_s     = ex_valid & (ex_is_branch | ex_jump);
    actual_s  = ex_jump | cond_taken_s;
    mispred_s = actual_s ^ ex_pred_taken;
    bht_upd_s = res_s & ~ex_jump;
    cnt_cur_s = bht_r[ex_idx_s];
    if (actual_s && (cnt_cur_s != CNT_MAX)) begin
      cnt_next_s = cnt_cur_s + CNT_ONE;
    end else if (!actual_s && (cnt_cur_s != CNT_ZERO)) begin
      cnt_next_s = cnt_cur_s - CNT_ONE;
    end else begin
      cnt_next_s = cnt_cur_s;
    end
  end

  // BHT flop array; jumps never train it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_r[i] <= CNT_INIT;
      end
    end else if (bht_upd_s) begin
      bht_r[ex_idx_s] <= cnt_next_s;
    end
  end

  // Registered resolution result, one cycle after EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch         <= BR_NONE;
      redirect       <= 1'b0;
      redirect_taken <= 1'b0;
    end else if (!res_s) begin
      branch         <= BR_NONE;
      redirect       <= 1'b0;
      redirect_taken <= 1'b0;
    end else begin
      if (ex_jump) begin
        branch <= BR_JUMP;
      end else if (cond_taken_s) begin
        branch <= BR_COND;
      end else begin
        branch <= BR_NONE;
      end
      redirect       <= mispred_s;
      redirect_taken <= actual_s;
    end
  end

`ifdef BRANCH_PRED_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
  logic [PERF_W-1:0] perf_branch_r;
  logic [PERF_W-1:0] perf_mispred_r;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branch_r  <= {PERF_W{1'b0}};
      perf_mispred_r <= {PERF_W{1'b0}};
    end else if (res_s) begin
      perf_branch_r <= perf_branch_r + PERF_ONE;
      if (mispred_s) begin
        perf_mispred_r <= perf_mispred_r + PERF_ONE;
      end
    end
  end

  assign perf_branch_cnt  = perf_branch_r;
  assign perf_mispred_cnt = perf_mispred_r;
`else
  assign perf_branch_cnt  = {PERF_W{1'b0}};
  assign perf_mispred_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised successor to the combinational branch resolver. Holds a direct-mapped branch history table (BHT) of saturating counters that supplies a taken/not-taken prediction at fetch. At execute, it resolves the real outcome from the ALU compare result and updates the table. It sits between IF (prediction) and EX (resolution) and emits a registered branch/redirect/mispredict result one cycle after resolution.

## Interface
- XLEN, 32, datapath and PC width
- BHT_ENTRIES, 64, number of BHT counters; power of two, at least 2
- CNT_W, 2, counter width; at least 2
- PERF_W, 32, width of the performance counters
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_pc  in  XLEN  PC being fetched
- pred_taken  out  1  combinational prediction for fetch_pc
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_branch  in  1  instruction is a conditional branch
- ex_jump  in  1  instruction is an unconditional jump (JAL/JALR)
- ex_pc  in  XLEN  PC of the EX instruction
- ex_pred_taken  in  1  prediction that was carried down the pipe
- ex_alu_result  in  XLEN  compare result from the ALU (SUB/SLT/SLTU)
- ex_cmp_opcode  in  3  compare op (funct3 encoding)
- branch  out  2  registered: bit0 = conditional taken, bit1 = jump
- redirect  out  1  registered: front end must fetch the resolved path
- redirect_taken  out  1  registered: 1 = go to target, 0 = go to pc+4
- perf_branch_cnt  out  PERF_W  resolved control-flow instructions
- perf_mispred_cnt  out  PERF_W  mispredictions

## Operation
- Index: idx = pc[IDX_W+1:2], where IDX_W = log2(BHT_ENTRIES). Bits [1:0] are ignored.
- Prediction: pred_taken = MSB of bht[idx(fetch_pc)].
- Resolution (cond_taken):
  - EQ 000: alu_result == 0
  - NE 001: alu_result != 0
  - LT 100 / LTU 110: alu_result[0] == 1
  - GE 101 / GEU 111: alu_result[0] == 0
  - Reserved 010 and 011: not taken
- res = ex_valid & (ex_is_branch | ex_jump). If both ex_is_branch and ex_jump are set, ex_jump wins.
- When res is true:
  - actual = ex_jump ? 1 : cond_taken
  - mispred = actual ^ ex_pred_taken
- Registered outputs at the next edge:
  - branch = {res & ex_jump, res & ~ex_jump & cond_taken}
  - redirect = res & mispred
  - redirect_taken = actual
- When res is false, all registered outputs load 0.
- BHT update happens only when res & ~ex_jump:
  - Saturating increment if actual is taken, saturating decrement otherwise.
  - A counter at max stays at max when taken; a counter at 0 stays at 0 when not taken.
  - Jumps never touch the BHT.
- Same-index fetch and update in one cycle: pred_taken returns the pre-update value (read-before-write).
- ex_pc aliasing across table wrap-around is intended behaviour; no tag check.

## Timing
- pred_taken: combinational from fetch_pc, zero latency.
- branch, redirect, redirect_taken: one-cycle latency from the cycle ex_valid is sampled.
- A BHT update is visible to pred_taken from the cycle after the update edge.
- Back-to-back resolutions every cycle are supported; no stall and no handshake.
- Reset:
  - Every BHT counter resets to weakly-not-taken, 2^(CNT_W-1)-1 (01 for CNT_W=2).
  - branch = 00, redirect = 0, redirect_taken = 0, both perf counters = 0.
  - A reset asserted mid-operation clears everything immediately, with no edge needed.
  - The first edge after reset deassertion behaves normally.

## Configuration
- Macro: BRANCH_PRED_PERF_EN.
- Defined:
  - perf_branch_cnt increments on every res.
  - perf_mispred_cnt increments on every res & mispred.
  - Both wrap modulo 2^PERF_W.
  - Both update on the same edge as the registered outputs.
- Undefined:
  - No counter flops are built.
  - Both perf ports are still present and tied to 0.

## Structure
- Shared package branch_pkg holds:
  - ALU_CMP_OP constants: EQ, NE, LT, GE, LTU, GEU.
  - Branch encoding constants: BR_NONE = 00, BR_COND = 01, BR_JUMP = 10.
- Sub-module branch_cond_eval holds the pure combinational resolution (ex_alu_result and ex_cmp_opcode to cond_taken). The existing branch bench can re-target it.
- The BHT is an array of flops (asynchronous reset is required), not inferred RAM.

## Test plan
- After reset, fetch_pc = 0x0 → pred_taken = 0. Perf counters are 0 (with the macro defined).
- Two resolutions of BEQ at ex_pc = 0x40 with alu_result = 0 and ex_pred_taken = 0:
  - First cycle → next cycle branch = 01, redirect = 1, redirect_taken = 1.
  - After the second, fetch_pc = 0x40 → pred_taken = 1 (counter 01 → 10 → 11).
- Saturation: three further taken BEQ at 0x40 keep the counter at 11. One BGE with alu_result = 1 (not taken) → counter 10, pred_taken still 1.
- JAL with ex_pred_taken = 0 → branch = 10, redirect = 1, redirect_taken = 1, BHT unchanged. A reserved opcode 010 with ex_is_branch = 1 → branch = 00.
- Simultaneous update and fetch on the same index (0x80, counter 01, taken) → pred_taken = 0 that cycle and 1 the next.
- Assert rst for 2 ns mid-stream (no clock edge) → all outputs 0 immediately, and fetch_pc = 0x40 → pred_taken = 0.
